// File: rtl/imm_narrow_unit_if.sv
// Valid/ready bus between the ALU result side and the immediate-field packer.
// The narrowing unit takes the slave view; the producer/consumer take master.
interface imm_narrow_unit_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_fit;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, out_fit
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, out_fit
  );
endinterface

// File: rtl/imm_narrow_unit.sv
// Narrows register words to immediate fields, flags whether zero/sign extension
// recovers the word, and counts non-recoverable words; 2-entry output buffer.
module imm_narrow_unit #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_narrow_unit_if.slave bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Signed fit needs the field's own sign bit to match every discarded bit.
  function automatic logic fit_f(input logic [IN_W-1:0] d, input logic sgn);
    logic r;
    if (sgn) begin
      r = (&d[IN_W-1:OUT_W-1]) | ~(|d[IN_W-1:OUT_W-1]);
    end else begin
      r = ~(|d[IN_W-1:OUT_W]);
    end
    return r;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [OUT_W-1:0]   head_data_r;
  logic               head_fit_r;
  logic [OUT_W-1:0]   tail_data_r;
  logic               tail_fit_r;
  logic [CNT_W-1:0]   ovf_cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               accept_s;
  logic               pop_s;
  logic               new_fit_s;
  logic               load_head_s;
  logic               load_tail_s;
  logic               shift_s;

  assign accept_s  = bus.in_valid & in_ready_r;
  assign pop_s     = out_valid_r & bus.out_ready;
  assign new_fit_s = fit_f(bus.in_data, bus.in_signed);

  // Buffer next-state and entry load/shift decode.
  always_comb begin
    state_nxt_s = state_r;
    load_head_s = 1'b0;
    load_tail_s = 1'b0;
    shift_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_ONE;
          load_head_s = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && !pop_s) begin
          state_nxt_s = ST_TWO;
          load_tail_s = 1'b1;
        end else if (accept_s && pop_s) begin
          state_nxt_s = ST_ONE;
          load_head_s = 1'b1;
        end else if (pop_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          state_nxt_s = ST_ONE;
          shift_s     = 1'b1;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State register with handshake flags registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Head entry; holds its last value when the buffer drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_r <= {OUT_W{1'b0}};
      head_fit_r  <= 1'b0;
    end else if (load_head_s) begin
      head_data_r <= bus.in_data[OUT_W-1:0];
      head_fit_r  <= new_fit_s;
    end else if (shift_s) begin
      head_data_r <= tail_data_r;
      head_fit_r  <= tail_fit_r;
    end else begin
      head_data_r <= head_data_r;
      head_fit_r  <= head_fit_r;
    end
  end

  // Second entry, only written when the head is occupied and not leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_data_r <= {OUT_W{1'b0}};
      tail_fit_r  <= 1'b0;
    end else if (load_tail_s) begin
      tail_data_r <= bus.in_data[OUT_W-1:0];
      tail_fit_r  <= new_fit_s;
    end else begin
      tail_data_r <= tail_data_r;
      tail_fit_r  <= tail_fit_r;
    end
  end

  // Overflow counter next value; clear wins over a same-cycle increment.
  always_comb begin
    cnt_nxt_s = ovf_cnt_r;
    if (clr_cnt) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (accept_s && !new_fit_s && (ovf_cnt_r != CNT_MAX)) begin
      cnt_nxt_s = ovf_cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = ovf_cnt_r;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_r <= {CNT_W{1'b0}};
    end else begin
      ovf_cnt_r <= cnt_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = head_data_r;
  assign bus.out_fit   = head_fit_r;
  assign ovf_cnt       = ovf_cnt_r;

endmodule

// File: tb/tb_imm_narrow_unit.sv
// Self-checking bench for imm_narrow_unit: scoreboard of narrowed words plus
// per-feature tasks for handshake, counter saturation/clear and async reset.
module tb_imm_narrow_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        clr2;
  logic [15:0] ovf;
  logic [1:0]  ovf2;

  imm_narrow_unit_if #(.IN_W(32), .OUT_W(12)) bus ();
  imm_narrow_unit_if #(.IN_W(32), .OUT_W(12)) bus2 ();

  imm_narrow_unit #(.IN_W(32), .OUT_W(12), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clr_cnt(clr), .ovf_cnt(ovf)
  );

  imm_narrow_unit #(.IN_W(32), .OUT_W(12), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .clr_cnt(clr2), .ovf_cnt(ovf2)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  int          exp_ovf = 0;
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  // Reference fit: does the word lie in the representable range of the field?
  function automatic logic exp_fit(input logic [31:0] d, input logic s);
    int v;
    v = $signed(d);
    if (s) return (v >= -2048) && (v <= 2047);
    else   return (d < 32'd4096);
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic s);
    logic f;
    f = exp_fit(d, s);
    exp_q.push_back({f, d[11:0]});
    if (!f && exp_ovf < 65535) exp_ovf++;
  endtask

  // Scoreboard: mid-cycle, a valid head with out_ready high leaves at the next edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h required no output", {bus.out_fit, bus.out_data});
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.out_fit, bus.out_data} !== mon_e) begin
          errors++;
          $display("FAIL sb_data: got fit/data %h required %h", {bus.out_fit, bus.out_data}, mon_e);
        end
      end
    end
  end

  // Offer one word until accepted (bounded); returns at the accept edge + 1.
  task automatic send(input logic [31:0] d, input logic s);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_signed = s;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        push_exp(d, s);
        break;
      end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=%b required 1 within 50 cycles", bus.in_ready);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.out_data !== 12'h000) begin errors++; $display("FAIL rst_out_data: got %h required 000", bus.out_data); end
    if (bus.out_fit !== 1'b0) begin errors++; $display("FAIL rst_out_fit: got %b required 0", bus.out_fit); end
    if (ovf !== 16'd0) begin errors++; $display("FAIL rst_ovf: got %0d required 0", ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_basic;
    bus.out_ready = 1'b1;
    send(32'h0000_0ABC, 1'b0);
    checks += 4;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", bus.out_valid); end
    if (bus.out_data !== 12'hABC) begin errors++; $display("FAIL basic_data: got %h required abc", bus.out_data); end
    if (bus.out_fit !== 1'b1) begin errors++; $display("FAIL basic_fit: got %b required 1", bus.out_fit); end
    if (ovf !== 16'd0) begin errors++; $display("FAIL basic_ovf: got %0d required 0", ovf); end
  endtask

  task automatic test_sign;
    send(32'hFFFF_F800, 1'b1);
    checks += 2;
    if (bus.out_data !== 12'h800) begin errors++; $display("FAIL sign_data: got %h required 800", bus.out_data); end
    if (bus.out_fit !== 1'b1) begin errors++; $display("FAIL sign_fit: got %b required 1", bus.out_fit); end
    send(32'hFFFF_F800, 1'b0);
    checks += 2;
    if (bus.out_fit !== 1'b0) begin errors++; $display("FAIL zero_fit: got %b required 0", bus.out_fit); end
    if (ovf !== 16'd1) begin errors++; $display("FAIL zero_ovf: got %0d required 1", ovf); end
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int p0;
    p0 = pops;
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = i; bus.in_signed = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b required 1", i, bus.in_ready); end
      else push_exp(i, 1'b0);
      @(posedge clk); #1;
    end
    bus.in_data = 32'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks += 2;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got in_ready=%b required 0", bus.in_ready); end
      if (bus.out_data !== 12'h001 || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold: got valid=%b data=%h required 1/001", bus.out_valid, bus.out_data);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(32'd3, 1'b0);
    repeat (3) @(posedge clk); #1;
    checks += 2;
    if (pops - p0 !== 3) begin errors++; $display("FAIL bp_pops: got %0d required 3", pops - p0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    int p0;
    logic [31:0] d;
    logic s;
    p0 = pops;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      case (i % 3)
        0: d = $urandom_range(0, 4095);
        1: d = 32'hFFFF_F000 | $urandom_range(0, 4095);
        default: d = $urandom;
      endcase
      s = $urandom_range(0, 1);
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_signed = s;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b required 1", i, bus.in_ready); end
      else push_exp(d, s);
      if (i > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble_%0d: got %b required 1", i, bus.out_valid); end
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks += 3;
    if (pops - p0 !== 20) begin errors++; $display("FAIL b2b_pops: got %0d required 20", pops - p0); end
    if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_drain: got %0d left required 0", exp_q.size()); end
    if (ovf !== exp_ovf[15:0]) begin errors++; $display("FAIL b2b_ovf: got %0d required %0d", ovf, exp_ovf); end
  endtask

  task automatic test_counter;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_ovf = 0;
    checks++;
    if (ovf !== 16'd0) begin errors++; $display("FAIL clr_ovf: got %0d required 0", ovf); end
    bus2.out_ready = 1'b1; bus2.in_signed = 1'b0; bus2.in_data = 32'h0001_0000;
    bus2.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus2.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf2 !== 2'd3) begin errors++; $display("FAIL sat_ovf: got %0d required 3", ovf2); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ovf2 !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d required 3", ovf2); end
    @(posedge clk); #1;
    bus2.in_valid = 1'b1; clr2 = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0; clr2 = 1'b0;
    checks++;
    if (ovf2 !== 2'd0) begin errors++; $display("FAIL clr_prio: got %0d required 0", ovf2); end
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    send(32'h0001_0000, 1'b0);
    send(32'd5, 1'b0);
    @(negedge clk);
    checks += 2;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_two: got in_ready=%b required 0", bus.in_ready); end
    if (ovf !== 16'd1) begin errors++; $display("FAIL mid_ovf_pre: got %0d required 1", ovf); end
    #2 rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b required 0", bus.out_valid); end
    if (ovf !== 16'd0) begin errors++; $display("FAIL mid_ovf: got %0d required 0", ovf); end
    exp_q.delete();
    exp_ovf = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_empty: got %b required 0", bus.out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_signed = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = 32'd0; bus2.in_signed = 1'b0; bus2.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_sign();
    test_backpressure();
    test_back_to_back();
    test_counter();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
